// File: rtl/threshold_alarm_mc.sv
// threshold_alarm_mc: per-channel Vpp / frequency window monitor. Each channel
// owns two alarm FSMs (Vpp and frequency) with sample-qualified debounce,
// return hysteresis, optional sticky latching and a new-alarm interrupt.
module threshold_alarm_mc #(
  parameter int NCH      = 2,
  parameter int VW       = 12,
  parameter int FW       = 26,
  parameter int LW       = 16,
  parameter int VSCALE   = 10000,
  parameter int FSCALE   = 1000,
  parameter int DEBOUNCE = 3,
  parameter int HYST     = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_vld,
  input  logic [NCH*VW-1:0] vmax,
  input  logic [NCH*VW-1:0] vmin,
  input  logic [NCH*FW-1:0] freq,
  input  logic [NCH*LW-1:0] vpp_min,
  input  logic [NCH*LW-1:0] vpp_max,
  input  logic [NCH*LW-1:0] fre_min,
  input  logic [NCH*LW-1:0] fre_max,
  input  logic              sticky,
  input  logic              clr,
  output logic [4*NCH-1:0]  led,
  output logic              irq
);

  // FSM index i = 2*ch + metric (metric 0 = Vpp, 1 = frequency); FSM i owns
  // led[2i] (low) and led[2i+1] (high), which matches the channel LED layout.
  localparam int NF = 2 * NCH;
  localparam int PW = VW + 14;
  // Common compare width: wide enough that limit + band never overflows.
  localparam int MW = ((FW + 1) > LW) ? FW + 2 : LW + 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [MW-1:0] VBAND = MW'(HYST);
  localparam logic [MW-1:0] FBAND = MW'(HYST * FSCALE / 1000);
  localparam logic [CW-1:0] DBN   = CW'(DEBOUNCE);

  // ST_NONE is only used as a "no qualifying direction" classification.
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_NONE = 2'd3
  } st_t;

  function automatic logic [LW-1:0] sat_lw(input logic [PW-1:0] p);
    if (p > PW'({LW{1'b1}})) return {LW{1'b1}};
    return p[LW-1:0];
  endfunction

  // Vpp never wraps: an inverted max/min pair reads as zero swing.
  function automatic logic [LW-1:0] vpp_scale(input logic [VW-1:0] mx,
                                              input logic [VW-1:0] mn);
    logic [PW-1:0] d;
    logic [PW-1:0] p;
    d = (mx >= mn) ? PW'(mx - mn) : '0;
    p = (d * PW'(VSCALE)) >> VW;
    return sat_lw(p);
  endfunction

  function automatic logic [FW:0] khz_to_hz(input logic [LW-1:0] k);
    return (FW + 1)'(k) * (FW + 1)'(FSCALE);
  endfunction

  // Which state the current sample argues for, relative to the present state.
  function automatic st_t classify(input st_t s, input logic [MW-1:0] v,
                                   input logic [MW-1:0] lo, input logic [MW-1:0] hi,
                                   input logic [MW-1:0] band);
    logic          lo_v;
    logic          hi_v;
    logic [MW-1:0] dn;
    lo_v = (v < lo);
    hi_v = (v > hi) && !lo_v;
    dn   = (hi > band) ? hi - band : '0;
    case (s)
      ST_OK:   return lo_v ? ST_LOW : (hi_v ? ST_HIGH : ST_NONE);
      ST_LOW:  return hi_v ? ST_HIGH : ((v >= lo + band) ? ST_OK : ST_NONE);
      ST_HIGH: return lo_v ? ST_LOW : ((v <= dn) ? ST_OK : ST_NONE);
      default: return ST_NONE;
    endcase
  endfunction

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c >= DBN) ? c : c + CW'(1);
  endfunction

  logic            vld_p1_q, vld_p1_d;
  logic [MW-1:0]   val_p1_q [NF];
  logic [MW-1:0]   val_p1_d [NF];
  logic [MW-1:0]   lo_p1_q  [NF];
  logic [MW-1:0]   lo_p1_d  [NF];
  logic [MW-1:0]   hi_p1_q  [NF];
  logic [MW-1:0]   hi_p1_d  [NF];

  st_t             st_q  [NF];
  st_t             st_d  [NF];
  st_t             tgt_q [NF];
  st_t             tgt_d [NF];
  logic [CW-1:0]   cnt_q [NF];
  logic [CW-1:0]   cnt_d [NF];
  st_t             cls   [NF];
  logic [CW-1:0]   run   [NF];

  logic [4*NCH-1:0] led_q, led_d;
  logic             irq_q, irq_d;

  // ---- stage 1: scale Vpp, convert frequency limits, capture on strobe ----
  // Stage-1 capture: hold previous values when no strobe, valid follows strobe.
  always_comb begin
    vld_p1_d = sample_vld;
    for (int i = 0; i < NF; i++) begin
      val_p1_d[i] = val_p1_q[i];
      lo_p1_d[i]  = lo_p1_q[i];
      hi_p1_d[i]  = hi_p1_q[i];
    end
    if (sample_vld) begin
      for (int c = 0; c < NCH; c++) begin
        val_p1_d[2*c]   = MW'(vpp_scale(vmax[c*VW +: VW], vmin[c*VW +: VW]));
        lo_p1_d[2*c]    = MW'(vpp_min[c*LW +: LW]);
        hi_p1_d[2*c]    = MW'(vpp_max[c*LW +: LW]);
        val_p1_d[2*c+1] = MW'(freq[c*FW +: FW]);
        lo_p1_d[2*c+1]  = MW'(khz_to_hz(fre_min[c*LW +: LW]));
        hi_p1_d[2*c+1]  = MW'(khz_to_hz(fre_max[c*LW +: LW]));
      end
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        val_p1_q[i] <= '0;
        lo_p1_q[i]  <= '0;
        hi_p1_q[i]  <= '0;
      end
    end else begin
      vld_p1_q <= vld_p1_d;
      for (int i = 0; i < NF; i++) begin
        val_p1_q[i] <= val_p1_d[i];
        lo_p1_q[i]  <= lo_p1_d[i];
        hi_p1_q[i]  <= hi_p1_d[i];
      end
    end
  end

  // ---- stage 2: debounced alarm FSMs, LED latching, interrupt ----
  // Per-FSM classification and the run length it would extend to.
  always_comb begin
    for (int i = 0; i < NF; i++) begin
      cls[i] = classify(st_q[i], val_p1_q[i], lo_p1_q[i], hi_p1_q[i],
                        (i % 2 == 0) ? VBAND : FBAND);
      run[i] = (cnt_q[i] != '0 && tgt_q[i] == cls[i]) ? cnt_inc(cnt_q[i]) : CW'(1);
    end
  end

  // Next state: a run of DEBOUNCE same-target samples moves the FSM.
  always_comb begin
    for (int i = 0; i < NF; i++) begin
      st_d[i]  = st_q[i];
      tgt_d[i] = tgt_q[i];
      cnt_d[i] = cnt_q[i];
    end
    if (vld_p1_q) begin
      for (int i = 0; i < NF; i++) begin
        if (cls[i] == ST_NONE) begin
          cnt_d[i] = '0;
        end else if (run[i] >= DBN) begin
          st_d[i]  = cls[i];
          tgt_d[i] = cls[i];
          cnt_d[i] = '0;
        end else begin
          tgt_d[i] = cls[i];
          cnt_d[i] = run[i];
        end
      end
    end
  end

  // LED/irq outputs: mirror FSM state, or latch entries until clr when sticky.
  always_comb begin
    led_d = led_q;
    for (int i = 0; i < NF; i++) begin
      if (sticky) begin
        led_d[2*i]   = (led_q[2*i] && !clr) ||
                       (st_d[i] == ST_LOW && st_q[i] != ST_LOW);
        led_d[2*i+1] = (led_q[2*i+1] && !clr) ||
                       (st_d[i] == ST_HIGH && st_q[i] != ST_HIGH);
      end else begin
        led_d[2*i]   = (st_d[i] == ST_LOW);
        led_d[2*i+1] = (st_d[i] == ST_HIGH);
      end
    end
    irq_d = |(led_d & ~led_q);
  end

  // Stage-2 state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NF; i++) begin
        st_q[i]  <= ST_OK;
        tgt_q[i] <= ST_OK;
        cnt_q[i] <= '0;
      end
      led_q <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        st_q[i]  <= st_d[i];
        tgt_q[i] <= tgt_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      led_q <= led_d;
      irq_q <= irq_d;
    end
  end

  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_threshold_alarm_mc.sv
// tb_threshold_alarm_mc: directed scenarios plus randomized traffic, every cycle
// compared against a window-of-samples reference model of the alarm rules.
module tb_threshold_alarm_mc;
  localparam int NCH = 2, VW = 12, FW = 26, LW = 16;
  localparam int VSCALE = 10000, FSCALE = 1000, DEBOUNCE = 3, HYST = 50;
  localparam int NF = 2 * NCH;

  logic              clk = 1'b0;
  logic              rst, sample_vld, sticky, clr;
  logic [NCH*VW-1:0] vmax, vmin;
  logic [NCH*FW-1:0] freq;
  logic [NCH*LW-1:0] vpp_min, vpp_max, fre_min, fre_max;
  logic [4*NCH-1:0]  led;
  logic              irq;

  always #5 clk = ~clk;

  threshold_alarm_mc #(
    .NCH(NCH), .VW(VW), .FW(FW), .LW(LW), .VSCALE(VSCALE), .FSCALE(FSCALE),
    .DEBOUNCE(DEBOUNCE), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .sample_vld(sample_vld), .vmax(vmax), .vmin(vmin),
    .freq(freq), .vpp_min(vpp_min), .vpp_max(vpp_max), .fre_min(fre_min),
    .fre_max(fre_max), .sticky(sticky), .clr(clr), .led(led), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: state 0 ok / 1 low / 2 high; wishes 0..2 or 3 = none.
  // A move happens once the last DEBOUNCE samples since the previous move all
  // wish for the same state.
  int               m_state [NF];
  int               m_since [NF];
  int               m_hist  [NF][DEBOUNCE];
  longint           p1_val [NF], p1_lo [NF], p1_hi [NF];
  bit               p1_vld;
  logic [4*NCH-1:0] m_led;
  logic             m_irq;

  function automatic int want(int st, longint v, longint lo, longint hi, longint band);
    bit     lv, hv;
    longint dn;
    lv = (v < lo);
    hv = (v > hi) && !lv;
    dn = (hi > band) ? hi - band : 0;
    if (st == 0) return lv ? 1 : (hv ? 2 : 3);
    if (st == 1) return hv ? 2 : ((v >= lo + band) ? 0 : 3);
    return lv ? 1 : ((v <= dn) ? 0 : 3);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_state[i] = 0;
      m_since[i] = 0;
      for (int k = 0; k < DEBOUNCE; k++) m_hist[i][k] = 3;
      p1_val[i] = 0; p1_lo[i] = 0; p1_hi[i] = 0;
    end
    p1_vld = 0;
    m_led  = '0;
    m_irq  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [4*NCH-1:0] ent, nl;
    int     t, band;
    bit     same;
    longint mx, mn, d, r;
    ent = '0;
    if (p1_vld) begin
      for (int i = 0; i < NF; i++) begin
        band = (i % 2 == 0) ? HYST : HYST * FSCALE / 1000;
        t = want(m_state[i], p1_val[i], p1_lo[i], p1_hi[i], band);
        for (int k = DEBOUNCE - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = t;
        m_since[i]++;
        same = (t != 3) && (m_since[i] >= DEBOUNCE);
        for (int k = 0; k < DEBOUNCE; k++) if (m_hist[i][k] != t) same = 0;
        if (same) begin
          if (t != 0) ent[2*i+t-1] = 1'b1;
          m_state[i] = t;
          m_since[i] = 0;
        end
      end
    end
    nl = '0;
    for (int i = 0; i < NF; i++) begin
      nl[2*i]   = (m_state[i] == 1);
      nl[2*i+1] = (m_state[i] == 2);
    end
    if (sticky) nl = (clr ? '0 : m_led) | ent;
    m_irq = |(nl & ~m_led);
    m_led = nl;
    if (sample_vld) begin
      for (int c = 0; c < NCH; c++) begin
        mx = longint'(vmax[c*VW +: VW]);
        mn = longint'(vmin[c*VW +: VW]);
        d  = (mx >= mn) ? mx - mn : 0;
        r  = (d * VSCALE) >> VW;
        if (r > (1 << LW) - 1) r = (1 << LW) - 1;
        p1_val[2*c]   = r;
        p1_lo[2*c]    = longint'(vpp_min[c*LW +: LW]);
        p1_hi[2*c]    = longint'(vpp_max[c*LW +: LW]);
        p1_val[2*c+1] = longint'(freq[c*FW +: FW]);
        p1_lo[2*c+1]  = longint'(fre_min[c*LW +: LW]) * FSCALE;
        p1_hi[2*c+1]  = longint'(fre_max[c*LW +: LW]) * FSCALE;
      end
    end
    p1_vld = sample_vld;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".led"}, 64'(led), 64'(m_led));
    check_eq({tag, ".irq"}, 64'(irq), 64'(m_irq));
  endtask

  task automatic strobe(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      sample_vld = 1'b1;
      tick(tag);
    end
    sample_vld = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    sample_vld = 1'b0;
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic set_vpp(input int c, input int mx, input int mn);
    vmax[c*VW +: VW] = VW'(mx);
    vmin[c*VW +: VW] = VW'(mn);
  endtask

  task automatic set_lim(input int c, input int vlo, input int vhi, input int flo, input int fhi);
    vpp_min[c*LW +: LW] = LW'(vlo);
    vpp_max[c*LW +: LW] = LW'(vhi);
    fre_min[c*LW +: LW] = LW'(flo);
    fre_max[c*LW +: LW] = LW'(fhi);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, ".rst_led"}, 64'(led), 64'd0);
    check_eq({tag, ".rst_irq"}, 64'(irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fmx;
    rst = 1'b1; sample_vld = 1'b0; sticky = 1'b0; clr = 1'b0;
    vmax = '0; vmin = '0; freq = '0;
    vpp_min = '0; vpp_max = '0; fre_min = '0; fre_max = '0;
    set_lim(0, 6000, 9000, 0, 200);
    set_lim(1, 0, 65535, 0, 100);
    freq[0 +: FW]  = FW'(100000);
    freq[FW +: FW] = FW'(100000);
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset.led", 64'(led), 64'd0);
    check_eq("reset.irq", 64'(irq), 64'd0);
    rst = 1'b0;

    // Case 1: real 5000 below 6000 raises Vpp-low after three samples.
    set_vpp(0, 2048, 0);
    strobe("c1", 2);
    idle("c1", 1);
    check_eq("c1.two_samples", 64'(led[0]), 64'd0);
    strobe("c1", 1);
    idle("c1", 1);
    check_eq("c1.led0_set", 64'(led[0]), 64'd1);
    check_eq("c1.irq_pulse", 64'(irq), 64'd1);
    idle("c1", 1);
    check_eq("c1.irq_single", 64'(irq), 64'd0);

    // Case 2: inside the return band holds the alarm; above it clears.
    set_vpp(0, 2466, 0);
    strobe("c2", 5);
    idle("c2", 1);
    check_eq("c2.hyst_hold", 64'(led[0]), 64'd1);
    set_vpp(0, 2499, 0);
    strobe("c2", 3);
    idle("c2", 1);
    check_eq("c2.recover", 64'(led[0]), 64'd0);

    // Case 3: ch1 frequency high limit 100 kHz is strict.
    strobe("c3", 3);
    idle("c3", 1);
    check_eq("c3.at_limit", 64'(led[7]), 64'd0);
    freq[FW +: FW] = FW'(100001);
    strobe("c3", 3);
    idle("c3", 1);
    check_eq("c3.over_limit", 64'(led[7]), 64'd1);
    freq[FW +: FW] = FW'(99000);
    strobe("c3", 3);
    idle("c3", 1);
    check_eq("c3.recover", 64'(led[7]), 64'd0);
    for (int k = 0; k < 6; k++) begin
      freq[FW +: FW] = (k % 3 == 2) ? FW'(99000) : FW'(100001);
      strobe("c3", 1);
    end
    freq[FW +: FW] = FW'(99000);
    idle("c3", 1);
    check_eq("c3.intermittent", 64'(led[7]), 64'd0);

    // Case 4: sticky latching and clr priority.
    sticky = 1'b1;
    set_lim(0, 6000, 9000, 50, 200);
    freq[0 +: FW] = FW'(40000);
    strobe("c4", 3);
    idle("c4", 1);
    check_eq("c4.set", 64'(led[2]), 64'd1);
    freq[0 +: FW] = FW'(60000);
    strobe("c4", 3);
    idle("c4", 1);
    check_eq("c4.latched", 64'(led[2]), 64'd1);
    clr = 1'b1;
    idle("c4", 1);
    clr = 1'b0;
    check_eq("c4.cleared", 64'(led[2]), 64'd0);
    freq[0 +: FW] = FW'(40000);
    strobe("c4", 3);
    clr = 1'b1;
    idle("c4", 1);
    clr = 1'b0;
    check_eq("c4.clr_vs_entry", 64'(led[2]), 64'd1);
    check_eq("c4.clr_vs_entry_irq", 64'(irq), 64'd1);
    sticky = 1'b0;
    freq[0 +: FW] = FW'(60000);
    strobe("c4", 3);
    idle("c4", 1);
    check_eq("c4.nonsticky_clear", 64'(led[2]), 64'd0);

    // Case 5: inverted min/max reads as zero swing; min>max config reports low.
    set_vpp(0, 100, 200);
    set_lim(1, 500, 100, 0, 200);
    set_vpp(1, 123, 0);
    strobe("c5", 3);
    idle("c5", 1);
    check_eq("c5.no_wrap_low", 64'(led[0]), 64'd1);
    check_eq("c5.no_wrap_high", 64'(led[1]), 64'd0);
    check_eq("c5.minmax_low", 64'(led[4]), 64'd1);
    check_eq("c5.minmax_high", 64'(led[5]), 64'd0);

    // Case 6: asynchronous reset with alarms up and mid-debounce.
    pulse_reset("c6a");
    strobe("c6", 2);
    pulse_reset("c6b");
    strobe("c6", 2);
    idle("c6", 1);
    check_eq("c6.count_restart", 64'(led), 64'd0);
    strobe("c6", 1);
    idle("c6", 1);
    check_eq("c6.after_restart", 64'(led[0]), 64'd1);

    // Randomized traffic against the model.
    for (int it = 0; it < 2000; it++) begin
      if (it % 250 == 0) begin
        for (int c = 0; c < NCH; c++) begin
          int lo, hi;
          lo = int'($urandom_range(1500, 5000));
          hi = lo + int'($urandom_range(200, 3000));
          if ($urandom_range(0, 7) == 0) set_lim(c, hi, lo, 110, 60);
          else set_lim(c, lo, hi, int'($urandom_range(60, 110)), int'($urandom_range(110, 200)));
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_vpp(c, int'($urandom_range(0, 4095)), int'($urandom_range(0, 1200)));
          fmx = int'(fre_max[c*LW +: LW]) * FSCALE;
          if ($urandom_range(0, 2) == 0)
            freq[c*FW +: FW] = FW'(fmx + int'($urandom_range(0, 120)) - 60);
          else
            freq[c*FW +: FW] = FW'($urandom_range(40000, 220000));
        end
      end
      sample_vld = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) sticky = ~sticky;
      if ($urandom_range(0, 499) == 0) pulse_reset("rnd");
      else tick("rnd");
    end
    sample_vld = 1'b0;
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
